// File: rtl/gbuf_pkg.sv
// Shared types and helpers for the dual-port global buffer and its clear engine.
package gbuf_pkg;

    localparam int unsigned ByteBits = 8;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

    // Even parity: the stored bit makes the total number of ones in byte+bit even.
    function automatic logic byte_parity(input logic [ByteBits-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/gbuf_clear_ctrl.sv
// Sequential clear engine: walks every entry once, issuing one zero-write per cycle.
module gbuf_clear_ctrl
    import gbuf_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_index
);

    localparam logic [ADDR_BITS-1:0] LastIndex = {ADDR_BITS{1'b1}};

    clr_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_busy = 1'b0;
        clr_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                // Hold at the last index so the counter never wraps.
                if (cnt_q == LastIndex) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_index = cnt_q;

endmodule

// File: rtl/global_buffer_dp.sv
// Simple dual-port global buffer with byte enables, write-first forwarding and a clear engine.
// Optional per-byte even parity storage and checking is enabled by defining GBUF_PARITY_EN.
module global_buffer_dp
    import gbuf_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned OUT_REG   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_start,
    output logic                          clr_busy,
    input  logic                          wr_en,
    input  logic [ADDR_BITS-1:0]          wr_index,
    input  logic [DATA_BITS/ByteBits-1:0] wr_be,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          rd_en,
    input  logic [ADDR_BITS-1:0]          rd_index,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          par_err
);

    localparam int unsigned NUM_BYTES = DATA_BITS / ByteBits;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;

    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_index;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 fwd_hit;
    logic [DATA_BITS-1:0] rd_word;
    logic                 rd_err;

    logic [DATA_BITS-1:0] mem [DEPTH];

    gbuf_clear_ctrl #(
        .ADDR_BITS (ADDR_BITS)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_we    (clr_we),
        .clr_index (clr_index)
    );

    // User ports are locked out for the whole clear sweep.
    assign wr_acc  = wr_en & ~clr_busy;
    assign rd_acc  = rd_en & ~clr_busy;
    assign fwd_hit = wr_acc & (wr_index == rd_index);

`ifdef GBUF_PARITY_EN
    logic [NUM_BYTES-1:0] par_mem [DEPTH];
    logic [NUM_BYTES-1:0] rd_par;
`endif

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_index] <= '0;
`ifdef GBUF_PARITY_EN
            par_mem[clr_index] <= '0;
`endif
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_index][i*ByteBits +: ByteBits] <= wr_data[i*ByteBits +: ByteBits];
`ifdef GBUF_PARITY_EN
                    par_mem[wr_index][i] <= byte_parity(wr_data[i*ByteBits +: ByteBits]);
`endif
                end
            end
        end
    end

    // Write-first: enabled bytes of a same-address write replace the stored bytes.
    always_comb begin
        rd_word = mem[rd_index];
`ifdef GBUF_PARITY_EN
        rd_par = par_mem[rd_index];
`endif
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (fwd_hit && wr_be[i]) begin
                rd_word[i*ByteBits +: ByteBits] = wr_data[i*ByteBits +: ByteBits];
`ifdef GBUF_PARITY_EN
                rd_par[i] = byte_parity(wr_data[i*ByteBits +: ByteBits]);
`endif
            end
        end
    end

`ifdef GBUF_PARITY_EN
    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_parity(rd_word[i*ByteBits +: ByteBits]) != rd_par[i]) begin
                rd_err = 1'b1;
            end
        end
    end
`else
    assign rd_err = 1'b0;
`endif

    logic                 s1_valid_q;
    logic [DATA_BITS-1:0] s1_data_q;
    logic                 s1_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_acc;
            s1_err_q   <= rd_acc & rd_err;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                 s2_valid_q;
        logic [DATA_BITS-1:0] s2_data_q;
        logic                 s2_err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_err_q   <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_valid_q & s1_err_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_valid = s2_valid_q;
        assign rd_data  = s2_data_q;
        assign par_err  = s2_err_q;
    end else begin : g_no_out_reg
        assign rd_valid = s1_valid_q;
        assign rd_data  = s1_data_q;
        assign par_err  = s1_err_q;
    end

endmodule

// File: tb/tb_global_buffer_dp.sv
// Directed self-checking bench for global_buffer_dp (default 256 x 32 configuration).
module tb_global_buffer_dp;

    localparam int unsigned ADDR_BITS = 8;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned OUT_REG   = 0;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned LAT       = OUT_REG + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr_start;
    logic                 clr_busy;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_index;
    logic [3:0]           wr_be;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_en;
    logic [ADDR_BITS-1:0] rd_index;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 par_err;

    int checks   = 0;
    int failures = 0;

    global_buffer_dp #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .OUT_REG   (OUT_REG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fill_val(input logic [7:0] i);
        return {i, 8'hA5, ~i, 8'h3C};
    endfunction

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_en = 1'b1; wr_index = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Read issued at one edge; data expected LAT-1 edges later, sampled #1 after the edge.
    task automatic rd_expect(input logic [7:0] a, input logic [31:0] exp, input logic perr,
                             input string tag);
        @(negedge clk);
        rd_en = 1'b1; rd_index = a;
        @(posedge clk); #1;
        rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            check({tag, "_early"}, {31'd0, rd_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_perr"}, {31'd0, par_err}, {31'd0, perr});
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, rd_valid}, 32'd0);
    endtask

    int          busy_cycles;
    int          valid_cnt;
    logic [31:0] pre_data;

    initial begin
        rst_n = 1'b0; clr_start = 1'b0; wr_en = 1'b0; wr_index = '0; wr_be = '0;
        wr_data = '0; rd_en = 1'b0; rd_index = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
        check("rst_par_err", {31'd0, par_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read.
        wr(8'd5, 32'hDEADBEEF, 4'hF);
        rd_expect(8'd5, 32'hDEADBEEF, 1'b0, "basic");

        // Byte enables: bytes 0 and 2 updated.
        wr(8'd7, 32'h11223344, 4'hF);
        wr(8'd7, 32'hAABBCCDD, 4'h5);
        rd_expect(8'd7, 32'h11BB33DD, 1'b0, "byte_en");

        // wr_be=0 leaves entry unchanged.
        wr(8'd7, 32'h99999999, 4'h0);
        rd_expect(8'd7, 32'h11BB33DD, 1'b0, "be_zero");

        // Same-cycle write/read, full and partial forwarding.
        wr(8'd3, 32'h00000000, 4'hF);
        @(negedge clk);
        wr_en = 1'b1; wr_index = 8'd3; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_index = 8'd3;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
        end
        check("fwd_full_valid", {31'd0, rd_valid}, 32'd1);
        check("fwd_full_data", rd_data, 32'hCAFEF00D);

        wr(8'd4, 32'h12345678, 4'hF);
        @(negedge clk);
        wr_en = 1'b1; wr_index = 8'd4; wr_data = 32'hFFFFFFFF; wr_be = 4'h3;
        rd_en = 1'b1; rd_index = 8'd4;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
        end
        check("fwd_part_data", rd_data, 32'h1234FFFF);
        rd_expect(8'd4, 32'h1234FFFF, 1'b0, "fwd_part_stored");

        // Fill the array, one write per cycle.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_index = 8'(i); wr_data = fill_val(8'(i)); wr_be = 4'hF;
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_expect(8'd128, fill_val(8'd128), 1'b0, "fill_128");

        // Full clear with a read of addr 1 accepted in the start cycle.
        @(negedge clk);
        clr_start = 1'b1; rd_en = 1'b1; rd_index = 8'd1;
        @(posedge clk); #1;
        clr_start = 1'b0; rd_en = 1'b0;
        busy_cycles = 0; valid_cnt = 0; pre_data = '0;
        while (clr_busy && busy_cycles < 400) begin
            busy_cycles++;
            if (rd_valid) begin
                valid_cnt++;
                pre_data = rd_data;
            end
            @(negedge clk);
            rd_en = 1'b1; rd_index = 8'd2;
            wr_en = (busy_cycles == 10); wr_index = 8'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
            @(posedge clk); #1;
        end
        if (rd_valid) valid_cnt++;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        check("clr_busy_cycles", busy_cycles, DEPTH);
        check("clr_valid_count", valid_cnt, 32'd1);
        check("clr_pre_data", pre_data, fill_val(8'd1));
        @(posedge clk); #1;
        check("clr_idle_busy", {31'd0, clr_busy}, 32'd0);
        rd_expect(8'd0, 32'd0, 1'b0, "clr_a0");
        rd_expect(8'd128, 32'd0, 1'b0, "clr_a128");
        rd_expect(8'd255, 32'd0, 1'b0, "clr_a255");

        // Usable again after the clear.
        wr(8'd10, 32'h0BADF00D, 4'hF);
        rd_expect(8'd10, 32'h0BADF00D, 1'b0, "post_clr");

        // Reset in the middle of a clear.
        wr(8'd50, 32'h50505050, 4'hF);
        wr(8'd200, 32'hC8C8C8C8, 4'hF);
        @(negedge clk);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        busy_cycles = 0;
        while (clr_busy && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles < 100) begin
                @(posedge clk); #1;
            end
        end
        check("mid_busy_cycles", busy_cycles, 32'd100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, clr_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_idle_busy", {31'd0, clr_busy}, 32'd0);
        rd_expect(8'd50, 32'd0, 1'b0, "mid_a50");
        rd_expect(8'd200, 32'hC8C8C8C8, 1'b0, "mid_a200");

`ifdef GBUF_PARITY_EN
        wr(8'd9, 32'h01020304, 4'hF);
        @(negedge clk);
        dut.mem[9][0] = ~dut.mem[9][0];
        rd_expect(8'd9, 32'h01020305, 1'b1, "par_flip");
        rd_expect(8'd200, 32'hC8C8C8C8, 1'b0, "par_clean");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
